// File: rtl/order_intake_arbiter_if.sv
// AXI-Stream bundle between the order-intent sources, the intake arbiter and the
// ingress unpacker. The master modport drives sources/sink; the slave modport is the arbiter.
interface order_intake_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 64
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]        s_tvalid;
  logic [N_SRC-1:0]        s_tready;
  logic [N_SRC*DATA_W-1:0] s_tdata;
  logic [N_SRC-1:0]        s_tlast;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tlast;
  logic [SRC_W-1:0]        m_tuser;

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
  );
endinterface

// File: rtl/order_intake_arbiter.sv
// Round-robin order arbiter: locks one source per multi-beat order, one output register stage.
// Optional ORD_ARB_PRIO0_EN gives source 0 strict priority over the round-robin group.
module order_intake_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kill,
  order_intake_arbiter_if.slave  bus,
  output logic                   grant_active,
  output logic [31:0]            ord_cnt
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_q;
  logic [SRC_W-1:0]    grant_q;
  logic [SRC_W-1:0]    rr_ptr_q;
  logic                m_tvalid_q;
  logic [DATA_W-1:0]   m_tdata_q;
  logic                m_tlast_q;
  logic [SRC_W-1:0]    m_tuser_q;
  logic [31:0]         ord_cnt_q;

  logic [DATA_W-1:0]   src_data [N_SRC];
  logic [N_SRC-1:0]    s_tready_d;
  logic [N_SRC-1:0]    req_mask;
  logic [2*N_SRC-1:0]  req_rot;
  logic                out_free;
  logic                beat_acc;
  logic                beat_last;
  logic                win_found_d;
  logic [SRC_W-1:0]    win_id_d;
  logic [SRC_W:0]      win_off_d;
  logic [SRC_W:0]      win_sum_d;
  logic [SRC_W-1:0]    rr_next_d;

  assign out_free = !m_tvalid_q || bus.m_tready;

  // Only the locked source sees ready, and it depends on registered state plus m_tready.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_data[gi]   = bus.s_tdata[gi*DATA_W +: DATA_W];
      assign s_tready_d[gi] = (state_q == LOCK) && (grant_q == SRC_W'(gi)) && out_free;
    end
  endgenerate

  assign bus.s_tready = s_tready_d;
  assign beat_acc     = |(bus.s_tvalid & s_tready_d);
  assign beat_last    = bus.s_tlast[grant_q];
  assign rr_next_d    = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;

`ifdef ORD_ARB_PRIO0_EN
  assign req_mask = bus.s_tvalid & ~{{(N_SRC-1){1'b0}}, 1'b1};
`else
  assign req_mask = bus.s_tvalid;
`endif

  // Rotate requests so bit k is source (rr_ptr + k) mod N_SRC; the lowest set bit wins.
  assign req_rot = {req_mask, req_mask} >> rr_ptr_q;

  always_comb begin
    win_found_d = 1'b0;
    win_off_d   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found_d = 1'b1;
        win_off_d   = (SRC_W+1)'(k);
      end
    end
    win_sum_d = {1'b0, rr_ptr_q} + win_off_d;
    if (win_sum_d >= (SRC_W+1)'(N_SRC)) begin
      win_sum_d = win_sum_d - (SRC_W+1)'(N_SRC);
    end
    win_id_d = win_sum_d[SRC_W-1:0];
`ifdef ORD_ARB_PRIO0_EN
    if (bus.s_tvalid[0]) begin
      win_found_d = 1'b1;
      win_id_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      ord_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!kill && win_found_d) begin
            grant_q <= win_id_d;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (beat_acc && beat_last) begin
            state_q <= IDLE;
`ifdef ORD_ARB_PRIO0_EN
            if (grant_q != '0) begin
              rr_ptr_q <= rr_next_d;
            end
`else
            rr_ptr_q <= rr_next_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase

      if (beat_acc) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= src_data[grant_q];
        m_tlast_q  <= beat_last;
        m_tuser_q  <= grant_q;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      if (m_tvalid_q && bus.m_tready && m_tlast_q && (ord_cnt_q != 32'hFFFF_FFFF)) begin
        ord_cnt_q <= ord_cnt_q + 32'd1;
      end
    end
  end

  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tuser  = m_tuser_q;
  assign grant_active = (state_q == LOCK);
  assign ord_cnt      = ord_cnt_q;
endmodule

// File: doc/order_intake_arbiter.md
# order_intake_arbiter

Round-robin arbiter that shares the single risk-check pipeline among `N_SRC` AXI-Stream order-intent sources (strategy engines, cancel path). It sits between the per-source ingress ports and the ingress unpacker. It grants one source at a time, holds the grant for a whole multi-beat order until `tlast`, and forwards beats through one output register stage. A kill input blocks new grants without truncating an order already in flight.

## Interface
- `N_SRC`, 4: number of requesting sources (2..8).
- `DATA_W`, 64: beat width in bits.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `s_tvalid`  in  N_SRC: per-source beat valid.
- `s_tready`  out  N_SRC: per-source ready.
- `s_tdata`  in  N_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- `s_tlast`  in  N_SRC: last beat of order, per source.
- `m_tvalid`  out  1: output beat valid.
- `m_tready`  in  1: downstream ready.
- `m_tdata`  out  DATA_W: output beat.
- `m_tlast`  out  1: last beat of order.
- `m_tuser`  out  SRC_W = max(1, $clog2(N_SRC)): id of the source the beat came from.
- `kill`  in  1: level-sensitive. While high, no new grant is issued.
- `grant_active`  out  1: high while a source is locked.
- `ord_cnt`  out  32: orders completed on the output, saturating.

## Operation
- FSM states:
  - IDLE: no grant.
    - If `kill`=0 and any `s_tvalid` is high, select a winner by round-robin. The search starts at `rr_ptr` and ascends modulo N_SRC.
    - Register `grant_id` and go to LOCK.
    - If `kill`=1 or no request, stay in IDLE.
  - LOCK: only `s_tready[grant_id]` may be high: `s_tready[grant_id] = !m_tvalid || m_tready`. All other `s_tready` bits are 0.
    - A beat is accepted when `s_tvalid[grant_id] && s_tready[grant_id]`. It loads the output register: `m_tdata`, `m_tlast`, `m_tuser=grant_id`, `m_tvalid=1`.
    - Accepting a beat with `s_tlast`=1 returns the FSM to IDLE and sets `rr_ptr = (grant_id+1) mod N_SRC`.
- Output register:
  - Cleared (`m_tvalid` to 0) when `m_tready`=1 and no new beat is loaded that cycle.
  - Held unchanged while `m_tvalid && !m_tready`.
- `ord_cnt` increments on every `m_tvalid && m_tready && m_tlast`. It saturates at 0xFFFF_FFFF.
- `grant_active` = (state == LOCK).
- Boundary rules:
  - A locked source that deasserts `s_tvalid` mid-order keeps the grant indefinitely. There is no timeout.
  - `kill` rising during LOCK has no effect until `tlast` is accepted; then the FSM parks in IDLE.
  - A single-beat order (first beat carries `tlast`) stays in LOCK for exactly one accept cycle.
  - `rr_ptr` wraps from N_SRC-1 to 0.
  - `s_tvalid` of non-granted sources is ignored; their data must be held by the source (AXI-Stream rules).

## Timing
- Reset values:
  - Outputs: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0, `s_tready`=0, `grant_active`=0, `ord_cnt`=0.
  - Internal: `rr_ptr`=0, state=IDLE.
- Reset asserted mid-order:
  - Drops the order; all state returns to reset values on the next edge.
  - Beats already presented downstream are lost. Downstream must tolerate a truncated order.
- Latency:
  - Request seen in IDLE at cycle t → grant registered, `s_tready` high at t+1.
  - First beat accepted at t+1 → `m_tvalid` at t+2.
- Throughput:
  - One beat per cycle while in LOCK with `m_tready`=1.
  - One arbitration bubble cycle between consecutive orders.
- `s_tready` depends combinationally on `m_tready` and registered state only. There is no path from `s_tvalid` to `s_tready`.

## Configuration
- `ORD_ARB_PRIO0_EN`:
  - Defined: source 0 has strict priority. In IDLE, if `s_tvalid[0]`=1 it wins regardless of `rr_ptr`, and `rr_ptr` is not updated after a source-0 grant. Sources 1..N_SRC-1 round-robin among themselves when source 0 is not requesting.
  - Undefined: pure round-robin over all sources as above.

## Test plan
- Reset, then all sources idle → all outputs 0, `grant_active`=0 for 10 cycles.
- Sources 0..3 each hold a 2-beat order (data 0xA0/0xA1, 0xB0/0xB1, …), `m_tready`=1 → output order 0,1,2,3 with `m_tuser` 0..3, beats contiguous per order, one bubble between orders, `ord_cnt`=4.
- Source 2 mid-order with `m_tready` held low 5 cycles → `m_tdata`/`m_tlast`/`m_tuser` stable, no beat dropped or duplicated, source 1 not granted until source 2's `tlast` is accepted.
- `kill`=1 asserted while source 1 is at beat 2 of 3 → beat 3 delivered, then IDLE with `grant_active`=0 despite pending requests; `kill`=0 → next grant is source 2.
- `rr_ptr`=3 after granting source 2, sources 0 and 3 requesting → source 3 granted, then source 0 (wrap).
- With `ORD_ARB_PRIO0_EN`: sources 0 and 1 continuously requesting single-beat orders → source 0 wins every arbitration. Without the macro → strict alternation 0,1,0,1.
